// File: rtl/pal_loader.sv
// Packs a downloaded palette byte stream (R,G,B per entry) into 24-bit palette writes.
// Optional PAL_LOADER_CHECKSUM_EN adds pal_checksum, a 16-bit sum of the stored bytes.
//
// state   | meaning
// S_IDLE  | waiting for a dl_active rising edge (live or latched)
// S_RECV  | accepting download bytes
// S_FLUSH | dl_active fell; draining a pending write, then finalising status
module pal_loader #(
   parameter int NUM_ENTRIES = 64,
   parameter int WRITE_GAP   = 2,
   parameter int ADDR_W      = 25
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              dl_active,
   input  logic              dl_wr,
   input  logic [ADDR_W-1:0] dl_addr,
   input  logic [7:0]        dl_data,
   output logic              dl_wait,
   output logic              load_color,
   output logic [23:0]       load_color_data,
   output logic [5:0]        load_color_index,
   output logic              pal_busy,
   output logic              pal_valid,
   output logic              pal_error
`ifdef PAL_LOADER_CHECKSUM_EN
   ,
   output logic [15:0]       pal_checksum
`endif
);

   localparam logic [ADDR_W-1:0] NBYTES = ADDR_W'(3 * NUM_ENTRIES);
   localparam int GAP_W = (WRITE_GAP > 1) ? $clog2(WRITE_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(WRITE_GAP - 1);

   typedef enum logic [1:0] {S_IDLE, S_RECV, S_FLUSH} state_t;

   state_t            state, state_nxt;
   logic              act_q, rise_pend, err_lock, full;
   logic [ADDR_W-1:0] cnt;
   logic [1:0]        phase;
   logic [5:0]        idx, hold_idx;
   logic [7:0]        r_q, g_q;
   logic [23:0]       hold_data;
   logic [GAP_W-1:0]  gap;
   logic              rise, start, gap_exp, issue, take, addr_ok, store, finish;

   assign rise    = dl_active & ~act_q;
   assign start   = (state == S_IDLE) & (rise | rise_pend);
   assign gap_exp = (gap == '0);
   assign issue   = full & gap_exp;
   // Stall while the gap runs, and never let a B byte land on an occupied holding register.
   assign dl_wait = full & (~gap_exp | (phase == 2'd2));
   assign take    = (state == S_RECV) & dl_active & dl_wr & ~dl_wait & ~err_lock;
   assign addr_ok = (dl_addr == cnt);
   assign store   = take & addr_ok & (cnt < NBYTES);
   assign finish  = (state == S_FLUSH) & ~full;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start)      state_nxt = S_RECV;
         S_RECV:  if (!dl_active) state_nxt = S_FLUSH;
         S_FLUSH: if (!full)      state_nxt = S_IDLE;
         default:                 state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // Previous-level preset high: a download left running across reset is not restarted.
         act_q            <= 1'b1;
         rise_pend        <= 1'b0;
         err_lock         <= 1'b0;
         full             <= 1'b0;
         cnt              <= '0;
         phase            <= 2'd0;
         idx              <= 6'd0;
         r_q              <= 8'd0;
         g_q              <= 8'd0;
         hold_data        <= 24'd0;
         hold_idx         <= 6'd0;
         gap              <= '0;
         load_color       <= 1'b0;
         load_color_data  <= 24'd0;
         load_color_index <= 6'd0;
         pal_busy         <= 1'b0;
         pal_valid        <= 1'b0;
         pal_error        <= 1'b0;
`ifdef PAL_LOADER_CHECKSUM_EN
         pal_checksum     <= 16'd0;
`endif
      end else begin
         act_q      <= dl_active;
         load_color <= issue;

         if (start)                         rise_pend <= 1'b0;
         else if (state != S_IDLE && rise)  rise_pend <= 1'b1;

         if (issue) begin
            load_color_data  <= hold_data;
            load_color_index <= hold_idx;
            gap              <= GAP_RELOAD;
         end else if (!gap_exp) begin
            gap <= gap - 1'b1;
         end

         if (store && phase == 2'd2) begin
            full      <= 1'b1;
            hold_data <= {r_q, g_q, dl_data};
            hold_idx  <= idx;
         end else if (issue) begin
            full <= 1'b0;
         end

         if (start) begin
            cnt       <= '0;
            phase     <= 2'd0;
            idx       <= 6'd0;
            err_lock  <= 1'b0;
            pal_valid <= 1'b0;
            pal_error <= 1'b0;
            pal_busy  <= 1'b1;
`ifdef PAL_LOADER_CHECKSUM_EN
            pal_checksum <= 16'd0;
`endif
         end else if (take) begin
            if (!addr_ok) begin
               pal_error <= 1'b1;
               err_lock  <= 1'b1;
            end else if (cnt != '1) begin
               cnt <= cnt + 1'b1;
            end
            if (store) begin
               if (phase == 2'd0) r_q <= dl_data;
               if (phase == 2'd1) g_q <= dl_data;
               if (phase == 2'd2) begin
                  phase <= 2'd0;
                  idx   <= idx + 1'b1;
               end else begin
                  phase <= phase + 1'b1;
               end
`ifdef PAL_LOADER_CHECKSUM_EN
               pal_checksum <= pal_checksum + {8'd0, dl_data};
`endif
            end
         end else if (finish) begin
            pal_valid <= ~pal_error & (cnt >= NBYTES);
            if (cnt < NBYTES) pal_error <= 1'b1;
            pal_busy <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pal_loader.sv
// Randomized bench for pal_loader: two instances (write gap 2 and 4) checked against a
// byte-list reference model of palette packing, status and checksum.
module tb_pal_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        act  [2];
   logic        wr   [2];
   logic [24:0] addr [2];
   logic [7:0]  data [2];
   logic        wait_o [2];
   logic        lc    [2];
   logic [23:0] dat_o [2];
   logic [5:0]  idx_o [2];
   logic        busy_o [2];
   logic        val_o  [2];
   logic        err_o  [2];
`ifdef PAL_LOADER_CHECKSUM_EN
   logic [15:0] csum [2];
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_p [2];
   int min_sp [2];
   bit saw_wait1 = 0;
   logic [29:0] got0[$];
   logic [29:0] got1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   pal_loader #(.WRITE_GAP(2)) u_dut0 (
      .clk(clk), .reset(reset), .dl_active(act[0]), .dl_wr(wr[0]), .dl_addr(addr[0]),
      .dl_data(data[0]), .dl_wait(wait_o[0]), .load_color(lc[0]), .load_color_data(dat_o[0]),
      .load_color_index(idx_o[0]), .pal_busy(busy_o[0]), .pal_valid(val_o[0]), .pal_error(err_o[0])
`ifdef PAL_LOADER_CHECKSUM_EN
      , .pal_checksum(csum[0])
`endif
   );

   pal_loader #(.WRITE_GAP(4)) u_dut1 (
      .clk(clk), .reset(reset), .dl_active(act[1]), .dl_wr(wr[1]), .dl_addr(addr[1]),
      .dl_data(data[1]), .dl_wait(wait_o[1]), .load_color(lc[1]), .load_color_data(dat_o[1]),
      .load_color_index(idx_o[1]), .pal_busy(busy_o[1]), .pal_valid(val_o[1]), .pal_error(err_o[1])
`ifdef PAL_LOADER_CHECKSUM_EN
      , .pal_checksum(csum[1])
`endif
   );

   always @(negedge clk) begin
      if (lc[0]) begin
         got0.push_back({idx_o[0], dat_o[0]});
         if (last_p[0] >= 0 && cyc - last_p[0] < min_sp[0]) min_sp[0] = cyc - last_p[0];
         last_p[0] = cyc;
      end
      if (lc[1]) begin
         got1.push_back({idx_o[1], dat_o[1]});
         if (last_p[1] >= 0 && cyc - last_p[1] < min_sp[1]) min_sp[1] = cyc - last_p[1];
         last_p[1] = cyc;
      end
      if (wait_o[1]) saw_wait1 = 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input int d, input logic [24:0] a, input logic [7:0] v);
      int n = 0;
      wr[d] = 1'b1; addr[d] = a; data[d] = v;
      while (wait_o[d] && n <= 500) begin
         @(negedge clk);
         n++;
      end
      if (n > 500) check("wait_release", {31'd0, wait_o[d]}, 0);
      @(negedge clk);
      wr[d] = 1'b0;
   endtask

   // mode: 0 data=addr&FF, 1 random, 2 all FF. skip_at: byte index whose address jumps by one.
   task automatic run_dl(input string name, input int d, input int nbytes, input int skip_at,
                         input int mode, input bit idle_gaps);
      logic [24:0] al[$];
      logic [7:0]  dl[$];
      logic [7:0]  sb[$];
      logic [29:0] exp_q[$];
      logic [29:0] g[$];
      logic [15:0] esum = 0;
      int cnt = 0, n = 0, ne;
      bit e = 0;
      for (int i = 0; i < nbytes; i++) begin
         al.push_back(25'(i + ((skip_at >= 0 && i >= skip_at) ? 1 : 0)));
         case (mode)
            0:       dl.push_back(8'(al[i]));
            1:       dl.push_back(8'($urandom_range(0, 255)));
            default: dl.push_back(8'hFF);
         endcase
      end
      foreach (al[i]) begin
         if (!e) begin
            if (al[i] != 25'(cnt)) e = 1;
            else begin
               if (cnt < 192) begin
                  sb.push_back(dl[i]);
                  esum += {8'd0, dl[i]};
               end
               cnt++;
            end
         end
      end
      ne = sb.size() / 3;
      for (int k = 0; k < ne; k++)
         exp_q.push_back({6'(k), sb[3*k], sb[3*k+1], sb[3*k+2]});

      if (d == 0) got0.delete(); else got1.delete();
      last_p[d] = -1; min_sp[d] = 1000;
      act[d] = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < nbytes; i++) begin
         send_byte(d, al[i], dl[i]);
         if (i == skip_at) check({name, ":err_at_skip"}, {31'd0, err_o[d]}, 1);
         if (idle_gaps && $urandom_range(0, 3) == 0) @(negedge clk);
      end
      act[d] = 1'b0;
      @(negedge clk);
      while (busy_o[d] && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check({name, ":busy"}, {31'd0, busy_o[d]}, 0);
      g = (d == 0) ? got0 : got1;
      check({name, ":n_writes"}, g.size(), exp_q.size());
      for (int k = 0; k < g.size() && k < exp_q.size(); k++)
         if (g[k] !== exp_q[k]) check({name, ":entry"}, {2'd0, g[k]}, {2'd0, exp_q[k]});
      check({name, ":valid"}, {31'd0, val_o[d]}, {31'd0, !e && cnt >= 192});
      check({name, ":error"}, {31'd0, err_o[d]}, {31'd0, e || cnt < 192});
`ifdef PAL_LOADER_CHECKSUM_EN
      check({name, ":checksum"}, {16'd0, csum[d]}, {16'd0, esum});
`endif
      if (mode == 0 && g.size() > 5) check({name, ":entry5"}, {2'd0, g[5]}, {2'd0, 6'd5, 24'h0F1011});
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #20_000_000;
      $display("FAIL global_timeout got=%0d exp=0", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         act[d] = 0; wr[d] = 0; addr[d] = 0; data[d] = 0; last_p[d] = -1; min_sp[d] = 1000;
      end
      repeat (3) @(negedge clk);
      check("reset_outs0", {25'd0, lc[0], busy_o[0], val_o[0], err_o[0], wait_o[0], |dat_o[0], |idx_o[0]}, 0);
      check("reset_outs1", {25'd0, lc[1], busy_o[1], val_o[1], err_o[1], wait_o[1], |dat_o[1], |idx_o[1]}, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      run_dl("seq192", 0, 192, -1, 0, 1'b0);
      run_dl("gap4", 1, 192, -1, 1, 1'b0);
      check("gap4:min_spacing", {31'd0, min_sp[1] >= 4}, 1);
      check("gap4:saw_wait", {31'd0, saw_wait1}, 1);
      check("seq192g2:min_spacing", {31'd0, min_sp[0] >= 2}, 1);
      run_dl("emph1536", 0, 1536, -1, 1, 1'b0);
      run_dl("short100", 0, 100, -1, 1, 1'b1);
      run_dl("skip", 0, 30, 11, 1, 1'b1);
      run_dl("rand_g4", 1, 150 + $urandom_range(0, 80), -1, 1, 1'b1);

      // reset mid-download with dl_active held high
      act[0] = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 50; i++) send_byte(0, 25'(i), 8'($urandom_range(0, 255)));
      reset = 1'b1;
      #1;
      check("midreset_outs", {25'd0, lc[0], busy_o[0], val_o[0], err_o[0], wait_o[0], |dat_o[0], |idx_o[0]}, 0);
      @(negedge clk);
      reset = 1'b0;
      got0.delete();
      for (int i = 50; i < 120; i++) send_byte(0, 25'(i), 8'($urandom_range(0, 255)));
      check("after_reset:n_writes", got0.size(), 0);
      check("after_reset:busy", {31'd0, busy_o[0]}, 0);
      act[0] = 1'b0;
      repeat (3) @(negedge clk);
      run_dl("post_reset", 0, 192, -1, 1, 1'b1);
      run_dl("all_ff", 0, 192, -1, 2, 1'b0);
`ifdef PAL_LOADER_CHECKSUM_EN
      check("all_ff:checksum_const", {16'd0, csum[0]}, 32'h0000BF40);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
